// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: one-cycle capture of decode results, bubbles on flush/miss/load-use, freezes on halt.
// Backpressure: mem_busy holds all EX state; luse_stall (combinational) holds PC and IF/ID.
module id_ex_latch #(
  parameter int CNT_W  = 16,
  parameter int SHAM_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              mem_busy,
  input  logic              flush,
  input  logic [31:0]       nPC_next,
  input  logic [31:0]       rdat1_next,
  input  logic [31:0]       rdat2_next,
  input  logic [31:0]       imm_next,
  input  logic [31:0]       lui_next,
  input  logic [4:0]        regDst_next,
  input  logic [4:0]        rs_next,
  input  logic [4:0]        rt_next,
  input  logic [SHAM_W:0]   shamt_next,
  input  logic              dREN_next,
  input  logic              dWEN_next,
  input  logic              regWr_next,
  input  logic              halt_next,
  input  logic [1:0]        regSel_next,
  input  logic [1:0]        ALUSrc_next,
  input  logic [1:0]        PCSrc_next,
  input  logic [3:0]        ALUOp_next,
  output logic [31:0]       ex_nPC,
  output logic [31:0]       ex_rdat1,
  output logic [31:0]       ex_rdat2,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_lui,
  output logic [4:0]        ex_regDst,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [SHAM_W:0]   ex_shamt,
  output logic              ex_dREN,
  output logic              ex_dWEN,
  output logic              ex_regWr,
  output logic              ex_halt,
  output logic              ex_valid,
  output logic [1:0]        ex_regSel,
  output logic [1:0]        ex_ALUSrc,
  output logic [1:0]        ex_PCSrc,
  output logic [3:0]        ex_ALUOp,
  output logic              luse_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [31:0]     npc;
    logic [31:0]     rdat1;
    logic [31:0]     rdat2;
    logic [31:0]     imm;
    logic [31:0]     lui;
    logic [4:0]      reg_dst;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [SHAM_W:0] shamt;
    logic            dren;
    logic            dwen;
    logic            reg_wr;
    logic            halt;
    logic            valid;
    logic [1:0]      reg_sel;
    logic [1:0]      alu_src;
    logic [1:0]      pc_src;
    logic [3:0]      alu_op;
  } ex_t;

  typedef enum logic {RUN, FROZEN} run_state_t;

  ex_t        ex_q;
  ex_t        dec;
  run_state_t state;

  always_comb begin
    dec         = '0;
    dec.npc     = nPC_next;
    dec.rdat1   = rdat1_next;
    dec.rdat2   = rdat2_next;
    dec.imm     = imm_next;
    dec.lui     = lui_next;
    dec.reg_dst = regDst_next;
    dec.rs      = rs_next;
    dec.rt      = rt_next;
    dec.shamt   = shamt_next;
    dec.dren    = dREN_next;
    dec.dwen    = dWEN_next;
    dec.reg_wr  = regWr_next;
    dec.halt    = halt_next;
    dec.valid   = 1'b1;
    dec.reg_sel = regSel_next;
    dec.alu_src = ALUSrc_next;
    dec.pc_src  = PCSrc_next;
    dec.alu_op  = ALUOp_next;
  end

  // A valid load in EX whose destination feeds the instruction in decode.
  assign luse_stall = ex_q.valid & ex_q.dren & ex_q.reg_wr & (ex_q.rt != 5'd0) &
                      ((ex_q.rt == rs_next) | (ex_q.rt == rt_next)) & ~flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q       <= '0;
      state      <= RUN;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_q  <= '0;
      state <= RUN;
    end else if (state == FROZEN || mem_busy) begin
      ex_q <= ex_q;
    end else if (ex_q.valid && ex_q.halt) begin
      // The halt itself stays parked in EX from here on.
      state <= FROZEN;
    end else if (luse_stall) begin
      ex_q <= '0;
      if (bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (!ihit) begin
      ex_q <= '0;
    end else begin
      ex_q <= dec;
    end
  end

  assign ex_nPC    = ex_q.npc;
  assign ex_rdat1  = ex_q.rdat1;
  assign ex_rdat2  = ex_q.rdat2;
  assign ex_imm    = ex_q.imm;
  assign ex_lui    = ex_q.lui;
  assign ex_regDst = ex_q.reg_dst;
  assign ex_rs     = ex_q.rs;
  assign ex_rt     = ex_q.rt;
  assign ex_shamt  = ex_q.shamt;
  assign ex_dREN   = ex_q.dren;
  assign ex_dWEN   = ex_q.dwen;
  assign ex_regWr  = ex_q.reg_wr;
  assign ex_halt   = ex_q.halt;
  assign ex_valid  = ex_q.valid;
  assign ex_regSel = ex_q.reg_sel;
  assign ex_ALUSrc = ex_q.alu_src;
  assign ex_PCSrc  = ex_q.pc_src;
  assign ex_ALUOp  = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_latch.sv
// Randomized and directed bench for id_ex_latch against a cycle-level behavioural model.
module tb_id_ex_latch;
  localparam int CNT_W  = 2;
  localparam int SHAM_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit, mem_busy, flush;
  logic [31:0] nPC_next, rdat1_next, rdat2_next, imm_next, lui_next;
  logic [4:0]  regDst_next, rs_next, rt_next;
  logic [SHAM_W:0] shamt_next;
  logic dREN_next, dWEN_next, regWr_next, halt_next;
  logic [1:0] regSel_next, ALUSrc_next, PCSrc_next;
  logic [3:0] ALUOp_next;
  logic [31:0] ex_nPC, ex_rdat1, ex_rdat2, ex_imm, ex_lui;
  logic [4:0]  ex_regDst, ex_rs, ex_rt;
  logic [SHAM_W:0] ex_shamt;
  logic ex_dREN, ex_dWEN, ex_regWr, ex_halt, ex_valid;
  logic [1:0] ex_regSel, ex_ALUSrc, ex_PCSrc;
  logic [3:0] ex_ALUOp;
  logic luse_stall;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_latch #(.CNT_W(CNT_W), .SHAM_W(SHAM_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .mem_busy(mem_busy), .flush(flush),
    .nPC_next(nPC_next), .rdat1_next(rdat1_next), .rdat2_next(rdat2_next),
    .imm_next(imm_next), .lui_next(lui_next), .regDst_next(regDst_next),
    .rs_next(rs_next), .rt_next(rt_next), .shamt_next(shamt_next),
    .dREN_next(dREN_next), .dWEN_next(dWEN_next), .regWr_next(regWr_next),
    .halt_next(halt_next), .regSel_next(regSel_next), .ALUSrc_next(ALUSrc_next),
    .PCSrc_next(PCSrc_next), .ALUOp_next(ALUOp_next),
    .ex_nPC(ex_nPC), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm),
    .ex_lui(ex_lui), .ex_regDst(ex_regDst), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_shamt(ex_shamt), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regWr(ex_regWr),
    .ex_halt(ex_halt), .ex_valid(ex_valid), .ex_regSel(ex_regSel),
    .ex_ALUSrc(ex_ALUSrc), .ex_PCSrc(ex_PCSrc), .ex_ALUOp(ex_ALUOp),
    .luse_stall(luse_stall), .bubble_cnt(bubble_cnt)
  );

  // Whole EX record, in the same field order as the output concatenation below.
  typedef struct packed {
    logic [31:0] npc, r1, r2, imm, lui;
    logic [4:0]  rd, rs, rt;
    logic [SHAM_W:0] sh;
    logic dren, dwen, regwr, halt, valid;
    logic [1:0] rsel, asrc, psrc;
    logic [3:0] aop;
  } rec_t;

  rec_t m_ex;
  bit   m_frozen;
  int   m_cnt;

  function automatic rec_t dut_rec();
    return rec_t'({ex_nPC, ex_rdat1, ex_rdat2, ex_imm, ex_lui, ex_regDst, ex_rs, ex_rt,
                   ex_shamt, ex_dREN, ex_dWEN, ex_regWr, ex_halt, ex_valid,
                   ex_regSel, ex_ALUSrc, ex_PCSrc, ex_ALUOp});
  endfunction

  function automatic rec_t dec_rec();
    rec_t r;
    r = '{npc: nPC_next, r1: rdat1_next, r2: rdat2_next, imm: imm_next, lui: lui_next,
          rd: regDst_next, rs: rs_next, rt: rt_next, sh: shamt_next, dren: dREN_next,
          dwen: dWEN_next, regwr: regWr_next, halt: halt_next, valid: 1'b1,
          rsel: regSel_next, asrc: ALUSrc_next, psrc: PCSrc_next, aop: ALUOp_next};
    return r;
  endfunction

  function automatic bit m_luse();
    return m_ex.valid && m_ex.dren && m_ex.regwr && m_ex.rt != 0 &&
           (m_ex.rt == rs_next || m_ex.rt == rt_next) && !flush;
  endfunction

  // Advance the model by one edge using the priority rules, then let the DUT take the edge.
  task automatic tick();
    bit lu;
    lu = m_luse();
    if (flush) begin
      m_ex = '0; m_frozen = 0;
    end else if (m_frozen || mem_busy) begin
      m_ex = m_ex;
    end else if (m_ex.valid && m_ex.halt) begin
      m_frozen = 1;
    end else if (lu) begin
      m_ex = '0;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (!ihit) begin
      m_ex = '0;
    end else begin
      m_ex = dec_rec();
    end
    @(posedge CLK); #1;
  endtask

  task automatic model_reset();
    m_ex = '0; m_frozen = 0; m_cnt = 0;
  endtask

  task automatic clear_inputs();
    ihit = 1'b0; mem_busy = 1'b0; flush = 1'b0;
    nPC_next = '0; rdat1_next = '0; rdat2_next = '0; imm_next = '0; lui_next = '0;
    regDst_next = '0; rs_next = '0; rt_next = '0; shamt_next = '0;
    dREN_next = 1'b0; dWEN_next = 1'b0; regWr_next = 1'b0; halt_next = 1'b0;
    regSel_next = '0; ALUSrc_next = '0; PCSrc_next = '0; ALUOp_next = '0;
  endtask

  task automatic rand_decode();
    nPC_next = $urandom; rdat1_next = $urandom; rdat2_next = $urandom;
    imm_next = $urandom; lui_next = $urandom;
    regDst_next = 5'($urandom); rs_next = 5'($urandom_range(0, 3));
    rt_next = 5'($urandom_range(0, 3)); shamt_next = (SHAM_W+1)'($urandom);
    dREN_next = 1'($urandom); dWEN_next = 1'($urandom); regWr_next = 1'($urandom);
    halt_next = 1'b0;
    regSel_next = 2'($urandom); ALUSrc_next = 2'($urandom);
    PCSrc_next = 2'($urandom); ALUOp_next = 4'($urandom);
  endtask

  task automatic do_reset();
    RST = 1'b1; #1;
    model_reset();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    rec_t got;
    clear_inputs(); do_reset();
    rand_decode(); ihit = 1'b1;
    tick(); tick();
    #2; RST = 1'b1; #1;
    model_reset();
    got = dut_rec();
    checks++;
    if (got !== rec_t'(0)) begin
      errors++; $display("FAIL reset_ex got %h want 0", got);
    end
    checks++;
    if (bubble_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", bubble_cnt);
    end
    RST = 1'b0;
  endtask

  task automatic test_capture();
    clear_inputs(); do_reset();
    ihit = 1'b1; rdat1_next = 32'hDEADBEEF; rt_next = 5'd5; ALUOp_next = 4'h3;
    tick();
    checks++;
    if (ex_rdat1 !== 32'hDEADBEEF || ex_rt !== 5'd5 || ex_ALUOp !== 4'h3 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture got rdat1=%h rt=%0d op=%0d v=%b want deadbeef 5 3 1",
               ex_rdat1, ex_rt, ex_ALUOp, ex_valid);
    end
  endtask

  task automatic test_load_use();
    clear_inputs(); do_reset();
    ihit = 1'b1; dREN_next = 1'b1; regWr_next = 1'b1; rt_next = 5'd8; rdat1_next = 32'h1111;
    tick();
    dREN_next = 1'b0; rt_next = 5'd1; rs_next = 5'd8; rdat1_next = 32'h2222; #1;
    checks++;
    if (luse_stall !== 1'b1) begin
      errors++; $display("FAIL luse_assert got %b want 1", luse_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 2'd1) begin
      errors++; $display("FAIL luse_bubble got v=%b cnt=%0d want 0 1", ex_valid, bubble_cnt);
    end
    checks++;
    if (luse_stall !== 1'b0) begin
      errors++; $display("FAIL luse_release got %b want 0", luse_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rdat1 !== 32'h2222) begin
      errors++; $display("FAIL luse_dependent got v=%b rs=%0d r1=%h want 1 8 2222",
                         ex_valid, ex_rs, ex_rdat1);
    end
    dREN_next = 1'b1; rt_next = 5'd0; rs_next = 5'd0;
    tick();
    dREN_next = 1'b0; #1;
    checks++;
    if (luse_stall !== 1'b0) begin
      errors++; $display("FAIL luse_r0 got %b want 0", luse_stall);
    end
  endtask

  task automatic test_hold_flush();
    rec_t held;
    clear_inputs(); do_reset();
    rand_decode(); ihit = 1'b1;
    tick();
    held = m_ex;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      tick();
      checks++;
      if (dut_rec() !== held) begin
        errors++; $display("FAIL hold_%0d got %h want %h", i, dut_rec(), held);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (dut_rec() !== rec_t'(0)) begin
      errors++; $display("FAIL flush_beats_busy got %h want 0", dut_rec());
    end
    flush = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_halt();
    rec_t held;
    clear_inputs(); do_reset();
    rand_decode(); dREN_next = 1'b0; halt_next = 1'b1; ihit = 1'b1;
    tick();
    held = m_ex;
    for (int i = 0; i < 12; i++) begin
      rand_decode();
      tick();
      checks++;
      if (ex_halt !== 1'b1 || dut_rec() !== held) begin
        errors++; $display("FAIL frozen_%0d got %h want %h", i, dut_rec(), held);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (dut_rec() !== rec_t'(0)) begin
      errors++; $display("FAIL halt_flush got %h want 0", dut_rec());
    end
    flush = 1'b0; rand_decode(); rdat2_next = 32'hCAFE0001;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rdat2 !== 32'hCAFE0001) begin
      errors++; $display("FAIL halt_resume got v=%b r2=%h want 1 cafe0001", ex_valid, ex_rdat2);
    end
    halt_next = 1'b1;
    tick(); tick(); tick();
    #2; RST = 1'b1; #1;
    model_reset();
    checks++;
    if (dut_rec() !== rec_t'(0)) begin
      errors++; $display("FAIL halt_reset got %h want 0", dut_rec());
    end
    RST = 1'b0; halt_next = 1'b0;
    rand_decode();
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin
      errors++; $display("FAIL halt_reset_run got v=%b want 1", ex_valid);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clear_inputs(); do_reset();
    ihit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dREN_next = 1'b1; regWr_next = 1'b1; rt_next = 5'd8; rs_next = 5'd0;
      tick();
      dREN_next = 1'b0; rt_next = 5'd0; rs_next = 5'd8;
      tick();
      checks++;
      if (bubble_cnt !== exp_cnt[i]) begin
        errors++; $display("FAIL sat_%0d got %0d want %0d", i, bubble_cnt, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_inputs(); do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_decode();
      ihit = ($urandom_range(0, 3) != 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (luse_stall !== m_luse()) begin
        errors++; $display("FAIL rand_luse_%0d got %b want %b", i, luse_stall, m_luse());
      end
      tick();
      checks++;
      if (dut_rec() !== m_ex) begin
        errors++; $display("FAIL rand_ex_%0d got %h want %h", i, dut_rec(), m_ex);
      end
      checks++;
      if (bubble_cnt !== m_cnt[CNT_W-1:0]) begin
        errors++; $display("FAIL rand_cnt_%0d got %0d want %0d", i, bubble_cnt, m_cnt);
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #12;
    test_reset();
    test_capture();
    test_load_use();
    test_hold_flush();
    test_halt();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
